// File: rtl/usb_conv_stage.sv
// usb_conv_stage
//   Streaming 3-tap valid-mode FIR between the FX2LP EP2 read path and the
//   EP6 write path. Each frame of N input words yields N-2 output words:
//   y = sat((K0*x[n-2] + K1*x[n-1] + K2*x[n]) >>> SHIFT).
//
// Ports
//   CLKOUT     clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    sample word (unsigned)          in_valid / in_ready handshake
//   in_last    final word of the input frame
//   out_data   filtered word                   out_valid / out_ready handshake
//   out_last   final output word of the frame
//   frame_cnt  words accepted in the current frame (saturating)
//   err_short  one-cycle pulse when a 1- or 2-word frame ends
//   busy       frame in progress or output pending
module usb_conv_stage #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int K0     = 1,
  parameter int K1     = 2,
  parameter int K2     = 1,
  parameter int SHIFT  = 2
) (
  input  logic              CLKOUT,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       frame_cnt,
  output logic              err_short,
  output logic              busy
);

  localparam int ACC_W = DATA_W + COEF_W + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Coefficients are first reduced to COEF_W bits, then sign-extended to the
  // accumulator width so the products are formed as signed ACC_W values.
  localparam logic signed [COEF_W-1:0] C0_N = COEF_W'(K0);
  localparam logic signed [COEF_W-1:0] C1_N = COEF_W'(K1);
  localparam logic signed [COEF_W-1:0] C2_N = COEF_W'(K2);
  localparam logic signed [ACC_W-1:0]  C0   = ACC_W'(C0_N);
  localparam logic signed [ACC_W-1:0]  C1   = ACC_W'(C1_N);
  localparam logic signed [ACC_W-1:0]  C2   = ACC_W'(C2_N);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_w0;
  logic [DATA_W-1:0] r_w1;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [15:0]       r_frame_cnt;
  logic              r_err_short;

  logic                    w_accept;
  logic signed [ACC_W-1:0] w_x0;
  logic signed [ACC_W-1:0] w_x1;
  logic signed [ACC_W-1:0] w_x2;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_sh;
  logic [DATA_W-1:0]       w_sat;

  // RUN may only accept when the output register is free or draining now.
  assign in_ready = rst_n & ((r_state != S_RUN) | ~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // Samples are unsigned: zero-extend into the signed accumulator domain.
  assign w_x0  = {{(ACC_W-DATA_W){1'b0}}, r_w0};
  assign w_x1  = {{(ACC_W-DATA_W){1'b0}}, r_w1};
  assign w_x2  = {{(ACC_W-DATA_W){1'b0}}, in_data};
  assign w_acc = (C0 * w_x0) + (C1 * w_x1) + (C2 * w_x2);
  assign w_sh  = w_acc >>> SHIFT;

  always_comb begin
    w_sat = w_sh[DATA_W-1:0];
    if (w_sh[ACC_W-1]) begin
      w_sat = '0;
    end else if (|w_sh[ACC_W-2:DATA_W]) begin
      w_sat = '1;
    end
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_w0        <= '0;
      r_w1        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_err_short <= 1'b0;
    end else begin
      r_err_short <= 1'b0;

      // A RUN accept below overrides this and keeps out_valid high.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept) begin
        if (in_last) begin
          r_frame_cnt <= 16'd0;
        end else if (r_frame_cnt != 16'hFFFF) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end

        case (r_state)
          S_IDLE: begin
            r_w1 <= in_data;
            if (in_last) begin
              r_err_short <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
          S_FILL: begin
            r_w0 <= r_w1;
            r_w1 <= in_data;
            if (in_last) begin
              r_err_short <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            r_out_data  <= w_sat;
            r_out_valid <= 1'b1;
            r_out_last  <= in_last;
            r_w0        <= r_w1;
            r_w1        <= in_data;
            if (in_last) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign frame_cnt = r_frame_cnt;
  assign err_short = r_err_short;
  assign busy      = (r_state != S_IDLE) | r_out_valid;

endmodule

// File: tb/tb_usb_conv_stage.sv
// tb_usb_conv_stage
//   Directed bench for usb_conv_stage. Three instances: u_dut (defaults),
//   u_neg (K0=-1, K1=0, K2=0, SHIFT=0) and u_sat (defaults, SHIFT=0).
//   The driver pushes hand-computed {last,data} expectations into a queue per
//   instance; a monitor pops and compares on every output transfer.
module tb_usb_conv_stage;

  logic        CLKOUT;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_last;
  logic [2:0]  err_short;
  logic [2:0]  busy;
  logic [15:0] out_data [3];
  logic [15:0] frame_cnt [3];

  logic [16:0] q0 [$];
  logic [16:0] q1 [$];
  logic [16:0] q2 [$];

  int passed = 0;
  int total  = 0;

  usb_conv_stage u_dut (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[0]),
    .in_last(in_last), .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready),
    .frame_cnt(frame_cnt[0]), .err_short(err_short[0]), .busy(busy[0])
  );

  usb_conv_stage #(.K0(-1), .K1(0), .K2(0), .SHIFT(0)) u_neg (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[1]),
    .in_last(in_last), .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready),
    .frame_cnt(frame_cnt[1]), .err_short(err_short[1]), .busy(busy[1])
  );

  usb_conv_stage #(.SHIFT(0)) u_sat (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[2]),
    .in_last(in_last), .in_ready(in_ready[2]), .out_data(out_data[2]),
    .out_valid(out_valid[2]), .out_last(out_last[2]), .out_ready(out_ready),
    .frame_cnt(frame_cnt[2]), .err_short(err_short[2]), .busy(busy[2])
  );

  initial CLKOUT = 1'b0;
  always #5 CLKOUT = ~CLKOUT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int s);
    logic [16:0] e;
    logic        empty;
    empty = 1'b0;
    e = '0;
    case (s)
      0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
      1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
      default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
    endcase
    if (empty) begin
      total++;
      $display("FAIL unexpected_output dut=%0d: got data %0d last %0d expected none",
               s, out_data[s], out_last[s]);
    end else begin
      chk($sformatf("out_data dut=%0d", s), 32'(out_data[s]), 32'(e[15:0]));
      chk($sformatf("out_last dut=%0d", s), 32'(out_last[s]), 32'(e[16]));
      $display("xfer dut=%0d data=%0d last=%0d", s, out_data[s], out_last[s]);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when valid & ready.
  always @(negedge CLKOUT) begin
    if (rst_n && out_ready) begin
      for (int s = 0; s < 3; s++) begin
        if (out_valid[s]) pop_chk(s);
      end
    end
  end

  // Drive one word into instance s; push the expected output if it produces one.
  task automatic send(input int s, input logic [15:0] d, input logic l,
                      input logic has, input logic [15:0] e);
    int n;
    in_data     = d;
    in_last     = l;
    in_valid[s] = 1'b1;
    n = 0;
    @(negedge CLKOUT);
    while (!in_ready[s] && n < 64) begin
      @(negedge CLKOUT);
      n++;
    end
    if (!in_ready[s]) begin
      total++;
      $display("FAIL send_timeout dut=%0d: got in_ready 0 expected 1 within 64 cycles", s);
      in_valid[s] = 1'b0;
      return;
    end
    @(posedge CLKOUT);
    #1;
    in_valid[s] = 1'b0;
    if (has) begin
      case (s)
        0: q0.push_back({l, e});
        1: q1.push_back({l, e});
        default: q2.push_back({l, e});
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 3'b000;
    in_data   = 16'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset in_ready", 32'(in_ready[0]), 32'd0);
    chk("reset out_valid", 32'(out_valid[0]), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    repeat (2) @(posedge CLKOUT);
    #1;
    rst_n = 1'b1;

    // 1. basic frame 10..50
    send(0, 16'd10, 1'b0, 1'b0, 16'd0);
    chk("t1 cnt1", 32'(frame_cnt[0]), 32'd1);
    send(0, 16'd20, 1'b0, 1'b0, 16'd0);
    chk("t1 cnt2", 32'(frame_cnt[0]), 32'd2);
    chk("t1 no out yet", 32'(out_valid[0]), 32'd0);
    send(0, 16'd30, 1'b0, 1'b1, 16'd20);
    chk("t1 cnt3", 32'(frame_cnt[0]), 32'd3);
    chk("t1 out_valid after 30", 32'(out_valid[0]), 32'd1);
    send(0, 16'd40, 1'b0, 1'b1, 16'd30);
    chk("t1 cnt4", 32'(frame_cnt[0]), 32'd4);
    send(0, 16'd50, 1'b1, 1'b1, 16'd40);
    chk("t1 cnt0", 32'(frame_cnt[0]), 32'd0);
    @(posedge CLKOUT); #1;
    chk("t1 idle busy", 32'(busy[0]), 32'd0);

    // 2. backpressure
    send(0, 16'd10, 1'b0, 1'b0, 16'd0);
    send(0, 16'd20, 1'b0, 1'b0, 16'd0);
    send(0, 16'd30, 1'b0, 1'b1, 16'd20);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge CLKOUT); #1;
      chk("t2 hold data", 32'(out_data[0]), 32'd20);
      chk("t2 in_ready low", 32'(in_ready[0]), 32'd0);
    end
    out_ready = 1'b1;
    send(0, 16'd40, 1'b0, 1'b1, 16'd30);
    send(0, 16'd50, 1'b1, 1'b1, 16'd40);
    repeat (2) @(posedge CLKOUT);
    #1;

    // 3. short frames
    send(0, 16'd7, 1'b1, 1'b0, 16'd0);
    chk("t3 err 1-word", 32'(err_short[0]), 32'd1);
    chk("t3 no out 1-word", 32'(out_valid[0]), 32'd0);
    @(posedge CLKOUT); #1;
    chk("t3 err pulse ends", 32'(err_short[0]), 32'd0);
    send(0, 16'd7, 1'b0, 1'b0, 16'd0);
    chk("t3 no err mid", 32'(err_short[0]), 32'd0);
    send(0, 16'd8, 1'b1, 1'b0, 16'd0);
    chk("t3 err 2-word", 32'(err_short[0]), 32'd1);
    chk("t3 no out 2-word", 32'(out_valid[0]), 32'd0);
    send(0, 16'd4, 1'b0, 1'b0, 16'd0);
    send(0, 16'd4, 1'b0, 1'b0, 16'd0);
    send(0, 16'd4, 1'b1, 1'b1, 16'd4);
    chk("t3 no err 3-word", 32'(err_short[0]), 32'd0);
    repeat (2) @(posedge CLKOUT);
    #1;

    // 4. saturation
    send(1, 16'd100, 1'b0, 1'b0, 16'd0);
    send(1, 16'd0, 1'b0, 1'b0, 16'd0);
    send(1, 16'd0, 1'b1, 1'b1, 16'd0);
    send(2, 16'd65535, 1'b0, 1'b0, 16'd0);
    send(2, 16'd65535, 1'b0, 1'b0, 16'd0);
    send(2, 16'd65535, 1'b1, 1'b1, 16'd65535);
    repeat (2) @(posedge CLKOUT);
    #1;

    // 5. reset mid-frame with an output pending
    send(0, 16'd10, 1'b0, 1'b0, 16'd0);
    send(0, 16'd20, 1'b0, 1'b0, 16'd0);
    send(0, 16'd30, 1'b0, 1'b1, 16'd20);
    send(0, 16'd40, 1'b0, 1'b0, 16'd0);
    chk("t5 pending before reset", 32'(out_valid[0]), 32'd1);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("t5 rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("t5 rst out_data", 32'(out_data[0]), 32'd0);
    chk("t5 rst frame_cnt", 32'(frame_cnt[0]), 32'd0);
    chk("t5 rst in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge CLKOUT); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(0, 16'd1, 1'b0, 1'b0, 16'd0);
    send(0, 16'd2, 1'b0, 1'b0, 16'd0);
    send(0, 16'd3, 1'b1, 1'b1, 16'd2);
    repeat (2) @(posedge CLKOUT);
    #1;

    // 6. back-to-back frames, B fills while A's output is held
    send(0, 16'd10, 1'b0, 1'b0, 16'd0);
    send(0, 16'd20, 1'b0, 1'b0, 16'd0);
    send(0, 16'd30, 1'b1, 1'b1, 16'd20);
    out_ready = 1'b0;
    send(0, 16'd5, 1'b0, 1'b0, 16'd0);
    send(0, 16'd5, 1'b0, 1'b0, 16'd0);
    chk("t6 A held valid", 32'(out_valid[0]), 32'd1);
    chk("t6 A held data", 32'(out_data[0]), 32'd20);
    out_ready = 1'b1;
    send(0, 16'd5, 1'b1, 1'b1, 16'd5);
    repeat (4) @(posedge CLKOUT);
    #1;

    chk("queue0 drained", 32'(q0.size()), 32'd0);
    chk("queue1 drained", 32'(q1.size()), 32'd0);
    chk("queue2 drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
